uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Byte buffer and sequencer directly upstream of uart_tx. Accepts bytes from
//   FrontPanel-side logic (wire/pipe writes) into a circular FIFO, then feeds
//   them one at a time to uart_tx via uart_data/send_byte. Waits on uart_done
//   between bytes; holds uart_data stable for the whole UART frame.
// PARAMETERS
//   DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 bytes (16); legal range 1..8
// PORTS
//   clk         in   1            system clock; uart_tx runs on the same clock
//   reset       in   1            synchronous, active-high
//   wr_en       in   1            write strobe; one byte per cycle
//   wr_data     in   8            byte to enqueue
//   flush       in   1            drop all queued bytes; clear overflow
//   full        out  1            FIFO holds DEPTH bytes
//   empty       out  1            FIFO holds 0 bytes
//   count       out  DEPTH_LOG2+1 bytes queued (excludes byte in flight)
//   overflow    out  1            sticky: a write was dropped while full
//   busy        out  1            !empty or byte in flight
//   uart_data   out  8            to uart_tx; stable from LOAD until back to IDLE
//   send_byte   out  1            to uart_tx; single-cycle start pulse
//   uart_done   in   1            from uart_tx; 1 = idle, falls <=2 clk after send_byte
// BEHAVIOUR
//   Reset: full=0 empty=1 count=0 overflow=0 busy=0 uart_data=8'h00
//     send_byte=0; pointers=0; FSM=S_IDLE. All outputs registered.
//   FIFO: wr_ptr/rd_ptr DEPTH_LOG2+1 bits, wrap modulo 2**(DEPTH_LOG2+1);
//     count = wr_ptr - rd_ptr; full = (count==DEPTH); empty = (count==0).
//   Write: accepted iff wr_en & !full (pre-edge value) & !flush. Write while full
//     -> byte dropped, overflow<=1. Write+pop same cycle: both happen, count
//     unchanged. Write on empty + pop never coincide (pop needs !empty pre-edge).
//   flush: pointers equalize (rd_ptr<=wr_ptr), overflow<=0; flush beats wr_en
//     (write dropped, overflow not set). Byte in flight is NOT aborted.
//   FSM:
//     S_IDLE      : if !empty & uart_done -> S_LOAD
//     S_LOAD      : uart_data<=mem[rd_ptr]; rd_ptr++ ; -> S_SEND
//     S_SEND      : send_byte=1 this cycle only; -> S_WAIT_ACK
//     S_WAIT_ACK  : wait uart_done==0 -> S_WAIT_DONE
//     S_WAIT_DONE : wait uart_done==1 -> S_IDLE
//   Latency: wr_en at cycle N into empty idle FIFO -> send_byte high cycle N+3.
//   Back-to-back: next S_LOAD no earlier than 1 clk after uart_done returns 1.
//   busy = (state!=S_IDLE) | !empty.
//   Reset mid-frame: FSM/pointers to reset state immediately; uart_tx shares the
//     same reset, so no handshake recovery is required.
// CONFIGURATION
//   UART_TX_FIFO_STATS_EN defined: adds outputs sent_count[15:0] (+1 per S_SEND)
//     and drop_count[15:0] (+1 per dropped write while full); both wrap at 16'hFFFF,
//     reset to 0, unaffected by flush.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//   1 write 8'h41, uart_done model idle -> send_byte pulse at N+3, uart_data=8'h41
//     held until uart_done re-rises; empty=1, busy=0 after.
//   2 16 writes back-to-back with uart_done held 0 -> full=1, count=16; 17th write
//     -> overflow=1, count stays 16; released bytes sent in write order.
//   3 writes 8'h00..8'h1F (32 bytes, 2 wraps) with draining model -> output
//     sequence exactly 00..1F, no gaps, no duplicates.
//   4 full FIFO, wr_en + pop same cycle -> write dropped, overflow=1; count 16->15.
//   5 flush during S_WAIT_DONE with 5 queued -> count=0, overflow=0, in-flight byte
//     completes, no further send_byte; flush+wr_en same cycle -> count stays 0.
//   6 reset asserted in S_WAIT_ACK -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO and sequencer feeding uart_tx one byte at a time.
// Define UART_TX_FIFO_STATS_EN to add the sent_count / drop_count statistics outputs.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic [7:0]            uart_data,
  output logic                  send_byte,
  input  logic                  uart_done
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]           sent_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          send_q, send_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    mem_q [DEPTH];

  logic wr_acc;
  logic wr_drop;
  logic pop;

  always_comb begin
    wr_acc  = wr_en & ~full_q & ~flush;
    wr_drop = wr_en & full_q & ~flush;
  end

  // A flush landing between IDLE and LOAD can leave nothing to read.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_q && uart_done) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (empty_q) begin
          state_d = S_IDLE;
        end else begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!uart_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (uart_done) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    ovf_d    = flush ? 1'b0 : (ovf_q | wr_drop);
    busy_d   = (state_d != S_IDLE) | ~empty_d;
    send_d   = (state_d == S_SEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      send_q   <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      send_q   <= send_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign uart_data = data_q;
  assign send_byte = send_q;

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sent_cnt_d = sent_cnt_q + 16'(state_q == S_SEND);
    drop_cnt_d = drop_cnt_q + 16'(wr_drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sent_count = sent_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-level model of the byte buffer plus a simple uart_tx
// responder; checks every cycle and pins the model with directed literals.
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam int FRAME = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
  logic          busy;
  logic [7:0]    uart_data;
  logic          send_byte;
  logic          uart_done;

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .busy      (busy),
    .uart_data (uart_data),
    .send_byte (send_byte),
    .uart_done (uart_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // uart_tx stand-in: goes busy on send_byte for FRAME cycles; hold forces not-idle.
  int ucnt = 0;
  bit hold = 0;
  assign uart_done = (ucnt == 0) && !hold;

  always @(negedge clk) begin
    if (reset) ucnt = 0;
    else if (send_byte === 1'b1) ucnt = FRAME;
    else if (ucnt > 0) ucnt = ucnt - 1;
  end

  // Queue model: bytes waiting, sticky overflow, and the one-at-a-time dispatcher.
  logic [7:0] mq[$];
  bit         m_ovf, m_grant, m_frame, m_low, m_send;
  logic [7:0] m_data;
  int         n;
  bit         pop, g_n, f_n, l_n;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_grant = 0; m_frame = 0;
      m_low = 0; m_send = 0; m_data = 8'h00;
    end else begin
      n   = mq.size();
      pop = m_grant && (n > 0);
      f_n = m_frame;
      l_n = m_low;
      if (m_grant) begin
        f_n = pop;
        l_n = 0;
      end else if (m_frame) begin
        if (m_low && uart_done) f_n = 0;
        else if (!m_low && !m_send && !uart_done) l_n = 1;
      end
      g_n = !m_grant && !m_frame && (n > 0) && uart_done;
      if (pop) m_data = mq.pop_front();
      m_send = pop;
      if (wr_en && !flush) begin
        if (n < DEPTH) mq.push_back(wr_data);
        else m_ovf = 1;
      end
      if (flush) begin
        mq.delete();
        m_ovf = 0;
      end
      m_grant = g_n;
      m_frame = f_n;
      m_low   = l_n;
    end
  end

  logic [7:0] sent_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, m_frame || m_grant || mq.size() > 0);
      chk("send_byte", send_byte, m_send);
      chk("uart_data", uart_data, m_data);
      if (send_byte === 1'b1) sent_q.push_back(uart_data);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic wait_send();
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (send_byte === 1'b1) break;
    end
    chk("wait_send", send_byte, 1'b1);
  endtask

  task automatic wait_sent(input int want, input int budget);
    for (int k = 0; k < budget && sent_q.size() < want; k++) cyc();
    chk("n_sent", sent_q.size(), want);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    @(posedge clk);
    chk_en = 1;
    cyc();
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 1'b0);
    cyc();
    reset = 1'b0;
    cyc();

    // 1: single byte latency and hold
    sent_q.delete();
    wr(8'h41);
    chk("t1_n1", send_byte, 1'b0);
    cyc();
    chk("t1_n2", send_byte, 1'b0);
    cyc();
    chk("t1_n3", send_byte, 1'b1);
    chk("t1_data", uart_data, 8'h41);
    repeat (12) cyc();
    chk("t1_empty", empty, 1'b1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_hold", uart_data, 8'h41);
    chk("t1_nsent", sent_q.size(), 1);

    // 2: fill to full, overflow, drain in order
    sent_q.delete();
    hold = 1;
    for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i));
    chk("t2_count", count, 16);
    chk("t2_full", full, 1'b1);
    chk("t2_ovf0", overflow, 1'b0);
    wr(8'hFF);
    chk("t2_ovf1", overflow, 1'b1);
    chk("t2_count17", count, 16);
    hold = 0;
    wait_sent(16, 400);
    for (int i = 0; i < sent_q.size(); i++)
      chk("t2_order", sent_q[i], 8'hA0 + 8'(i));
    repeat (8) cyc();
    chk("t2_drained", empty, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t2_ovf_clr", overflow, 1'b0);

    // 3: 32 bytes through the ring, two pointer wraps
    sent_q.delete();
    for (int i = 0; i < 32; i++) begin
      for (int g = 0; g < 500 && full; g++) cyc();
      wr(8'(i));
    end
    wait_sent(32, 2000);
    for (int i = 0; i < sent_q.size(); i++)
      chk("t3_seq", sent_q[i], 8'(i));
    chk("t3_ovf", overflow, 1'b0);
    repeat (8) cyc();

    // 4: write while full coincides with a pop
    sent_q.delete();
    hold = 1;
    for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i));
    chk("t4_full", full, 1'b1);
    hold = 0;
    cyc();
    wr(8'hEE);
    chk("t4_count", count, 15);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_send", send_byte, 1'b1);
    chk("t4_data", uart_data, 8'hC0);
    wait_sent(16, 400);
    if (sent_q.size() == 16) chk("t4_last", sent_q[15], 8'hCF);
    repeat (8) cyc();

    // 5: flush with a byte in flight
    hold = 1;
    for (int i = 0; i < 6; i++) wr(8'h50 + 8'(i));
    chk("t5_count6", count, 6);
    chk("t5_ovf_pre", overflow, 1'b1);
    sent_q.delete();
    hold = 0;
    wait_send();
    chk("t5_count5", count, 5);
    cyc();
    cyc();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    chk("t5_count0", count, 0);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_busy", busy, 1'b1);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h98;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    chk("t5_count0b", count, 0);
    repeat (20) cyc();
    chk("t5_nsent", sent_q.size(), 1);
    chk("t5_byte", sent_q[0], 8'h50);
    chk("t5_idle", busy, 1'b0);

    // 6: reset during WAIT_ACK
    hold = 1;
    for (int i = 0; i < 17; i++) wr(8'h70 + 8'(i));
    chk("t6_ovf", overflow, 1'b1);
    hold = 0;
    wait_send();
    cyc();
    reset = 1'b1;
    cyc();
    chk("t6_full", full, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_count", count, 0);
    chk("t6_ovf0", overflow, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_data", uart_data, 8'h00);
    chk("t6_send", send_byte, 1'b0);
    reset = 1'b0;
    cyc();
    wr(8'h5A);
    wait_send();
    chk("t6_after", uart_data, 8'h5A);
    repeat (12) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
